merlin_pfu_mo: RTL and testbench
================================

MERLIN_PFU_MO -- requirements
Module: merlin_pfu_mo

Interface
REQ-001 SHALL have parameter C_FIFO_DEPTH_X, default 2: instruction buffer depth = 2^C_FIFO_DEPTH_X entries.
REQ-002 SHALL have parameter C_OSD_X, default 2: maximum outstanding ibus requests = 2^C_OSD_X.
REQ-003 SHALL have parameter C_RESET_VECTOR, default all-zero `RV_XLEN: fetch address after reset.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk_i  in  1  clock; all state updates on its rising edge.
REQ-006 reset_i  in  1  asynchronous active-high reset.
REQ-007 ireqready_i  in  1  ibus request accepted when high with ireqvalid_o.
REQ-008 ireqvalid_o  out  1  ibus request valid.
REQ-009 ireqhpl_o  out  2  privilege level, equal to exs_hpl_i.
REQ-010 ireqaddr_o  out  `RV_XLEN  word-aligned fetch address (pc_q with bits [1:0] zero).
REQ-011 irspready_o  out  1  constant 1.
REQ-012 irspvalid_i / irsprerr_i / irspdata_i  in  1 / 1 / `RV_XLEN  in-order ibus response, error flag, data.
REQ-013 ids_dav_o  out  1  buffer non-empty.
REQ-014 ids_ack_i  in  1  decoder consumes head entry.
REQ-015 ids_sofid_o / ids_ins_o / ids_ferr_o / ids_pc_o  out  `RV_SOFID_SZ / 32 / 1 / `RV_XLEN  head-entry fields.
REQ-016 exs_pc_wr_i / exs_pc_din_i  in  1 / `RV_XLEN  vector request and target.
REQ-017 exs_hpl_i  in  2  current privilege level.

Function
REQ-018 Request: request = ireqvalid_o & ireqready_i; response = irspvalid_i (always accepted).
REQ-019 ireqvalid_o SHALL = ~exs_pc_wr_i & (osd_q < 2^C_OSD_X) & (fifo_count + live_q < 2^C_FIFO_DEPTH_X), where osd_q = all in-flight requests, live_q = in-flight non-stale requests; width of counters C_OSD_X+1 / C_FIFO_DEPTH_X+1, no wrap.
REQ-020 osd_q: +1 on request only, -1 on response only, unchanged on both or neither.
REQ-021 Each request SHALL push pc_q into an address queue of depth 2^C_OSD_X; every response pops it; queue never overflows given REQ-019.
REQ-022 pc_q SHALL increment by 4 on request; exs_pc_wr_i loads exs_pc_din_i with priority over request.
REQ-023 On exs_pc_wr_i: buffer flushed (fifo_count 0, dav 0 next cycle); drop_q <= osd_q - response; live_q <= 0.
REQ-024 Response with drop_q != 0 SHALL be discarded and decrement drop_q; otherwise written to buffer with {sofid, irsprerr_i, popped address, irspdata_i} and live_q decremented.
REQ-025 Response in the same cycle as exs_pc_wr_i SHALL be discarded and not counted in drop_q.
REQ-026 sofid: first buffered response after vectoring tagged `RV_SOFID_JUMP, all others `RV_SOFID_RUN.
REQ-027 Buffer: write and read same cycle permitted, count unchanged; ids_ack_i with buffer empty ignored; head fields combinational from head entry.
REQ-028 Response latency: buffered data visible on ids_* one cycle after irspvalid_i.
REQ-029 Throughput: one request per cycle sustainable while credits remain.

Reset
REQ-030 On reset_i: pc_q = C_RESET_VECTOR, osd_q = live_q = drop_q = 0, buffer empty, sofid pending JUMP.
REQ-031 During/after reset: ids_dav_o = 0; ireqvalid_o = 1 once reset_i low (unless exs_pc_wr_i); ireqaddr_o = C_RESET_VECTOR.
REQ-032 Reset mid-operation SHALL abandon all in-flight requests; later stray responses not required to be handled.

Verification
REQ-033 Reset, ireqready_i=1, 1-cycle response latency -> addresses 0x0,0x4,0x8 issued back-to-back; first entry sofid JUMP, pc 0x0.
REQ-034 ireqready_i=1, irspvalid_i=0, defaults -> exactly 4 requests then ireqvalid_o=0 (osd full).
REQ-035 4 outstanding, exs_pc_wr_i target 0x100 -> next 4 responses dropped, ids_dav_o stays 0, next request 0x100, its entry sofid JUMP, pc 0x100.
REQ-036 Buffer filled to 4 with no ack -> ireqvalid_o=0; one ids_ack_i -> one new request issued.
REQ-037 irsprerr_i=1 on response for 0x8 -> entry ids_ferr_o=1, ids_pc_o=0x8; neighbours ferr 0.
REQ-038 Simultaneous response and exs_pc_wr_i with osd_q=2 -> drop_q=1, response not buffered.

Source files
------------

// File: rtl/merlin_pfu_mo_if.sv
// Bundle for the merlin prefetch unit: instruction bus request/response
// channel, decoder-side head-entry view and execute-stage vector/privilege
// inputs. The master side is the prefetch unit itself.
`ifndef RV_XLEN
`define RV_XLEN 32
`endif
`ifndef RV_SOFID_SZ
`define RV_SOFID_SZ 2
`endif
`ifndef RV_SOFID_RUN
`define RV_SOFID_RUN 2'b00
`endif
`ifndef RV_SOFID_JUMP
`define RV_SOFID_JUMP 2'b01
`endif

interface merlin_pfu_mo_if;
    // instruction bus request channel
    logic                    ireqready_i;
    logic                    ireqvalid_o;
    logic [1:0]              ireqhpl_o;
    logic [`RV_XLEN-1:0]     ireqaddr_o;
    // instruction bus response channel
    logic                    irspready_o;
    logic                    irspvalid_i;
    logic                    irsprerr_i;
    logic [`RV_XLEN-1:0]     irspdata_i;
    // decoder side
    logic                    ids_dav_o;
    logic                    ids_ack_i;
    logic [`RV_SOFID_SZ-1:0] ids_sofid_o;
    logic [31:0]             ids_ins_o;
    logic                    ids_ferr_o;
    logic [`RV_XLEN-1:0]     ids_pc_o;
    // execute stage side
    logic                    exs_pc_wr_i;
    logic [`RV_XLEN-1:0]     exs_pc_din_i;
    logic [1:0]              exs_hpl_i;

    modport master (
        input  ireqready_i,
        output ireqvalid_o,
        output ireqhpl_o,
        output ireqaddr_o,
        output irspready_o,
        input  irspvalid_i,
        input  irsprerr_i,
        input  irspdata_i,
        output ids_dav_o,
        input  ids_ack_i,
        output ids_sofid_o,
        output ids_ins_o,
        output ids_ferr_o,
        output ids_pc_o,
        input  exs_pc_wr_i,
        input  exs_pc_din_i,
        input  exs_hpl_i
    );

    modport slave (
        output ireqready_i,
        input  ireqvalid_o,
        input  ireqhpl_o,
        input  ireqaddr_o,
        input  irspready_o,
        output irspvalid_i,
        output irsprerr_i,
        output irspdata_i,
        input  ids_dav_o,
        output ids_ack_i,
        input  ids_sofid_o,
        input  ids_ins_o,
        input  ids_ferr_o,
        input  ids_pc_o,
        output exs_pc_wr_i,
        output exs_pc_din_i,
        output exs_hpl_i
    );
endinterface

// File: rtl/merlin_pfu_mo.sv
// Merlin prefetch unit. Issues word-aligned instruction fetches, tracks the
// addresses of in-flight requests in an in-order queue and collects the
// responses into an instruction buffer read by the decoder. A vector request
// from the execute stage redirects fetching, flushes the buffer and marks
// every still-outstanding response as stale so it is discarded on return.
// Credits are counted so that every non-stale response is guaranteed a
// buffer slot: the response channel can therefore always be accepted.
`ifndef RV_XLEN
`define RV_XLEN 32
`endif
`ifndef RV_SOFID_SZ
`define RV_SOFID_SZ 2
`endif
`ifndef RV_SOFID_RUN
`define RV_SOFID_RUN 2'b00
`endif
`ifndef RV_SOFID_JUMP
`define RV_SOFID_JUMP 2'b01
`endif

module merlin_pfu_mo #(
    parameter int unsigned         C_FIFO_DEPTH_X = 2,
    parameter int unsigned         C_OSD_X        = 2,
    parameter logic [`RV_XLEN-1:0] C_RESET_VECTOR = '0
) (
    input  logic            clk_i,
    input  logic            reset_i,
    merlin_pfu_mo_if.master bus
);

    localparam int unsigned FIFO_N = 2 ** C_FIFO_DEPTH_X;
    localparam int unsigned OSD_N  = 2 ** C_OSD_X;
    // wide enough to hold fifo_count + live_q without wrapping
    localparam int unsigned SUM_W  =
        ((C_FIFO_DEPTH_X > C_OSD_X) ? C_FIFO_DEPTH_X : C_OSD_X) + 2;

    typedef logic [`RV_XLEN-1:0]     addr_t;
    typedef logic [C_OSD_X:0]        ocnt_t;
    typedef logic [C_FIFO_DEPTH_X:0] fcnt_t;
    typedef logic [SUM_W-1:0]        sum_t;

    localparam ocnt_t OSD_LIM  = ocnt_t'(OSD_N);
    localparam sum_t  FIFO_LIM = sum_t'(FIFO_N);

    // up/down counter step; holds when both or neither strobe is set
    function automatic ocnt_t ocnt_step(input ocnt_t c, input logic up, input logic dn);
        ocnt_t r;
        r = c;
        if (up && !dn) begin
            r = c + 1'b1;
        end else if (dn && !up) begin
            r = c - 1'b1;
        end
        return r;
    endfunction

    function automatic fcnt_t fcnt_step(input fcnt_t c, input logic up, input logic dn);
        fcnt_t r;
        r = c;
        if (up && !dn) begin
            r = c + 1'b1;
        end else if (dn && !up) begin
            r = c - 1'b1;
        end
        return r;
    endfunction

    // control state
    addr_t                     pc_q;
    ocnt_t                     osd_q;
    ocnt_t                     live_q;
    ocnt_t                     drop_q;
    fcnt_t                     fifo_cnt_q;
    logic [C_OSD_X-1:0]        aq_wr_q;
    logic [C_OSD_X-1:0]        aq_rd_q;
    logic [C_FIFO_DEPTH_X-1:0] fb_wr_q;
    logic [C_FIFO_DEPTH_X-1:0] fb_rd_q;
    logic                      jump_pend_q;

    // storage (data only, never reset)
    addr_t                     aq_mem   [OSD_N];
    logic [31:0]               fb_ins   [FIFO_N];
    addr_t                     fb_pc    [FIFO_N];
    logic                      fb_ferr  [FIFO_N];
    logic [`RV_SOFID_SZ-1:0]   fb_sofid [FIFO_N];

    // per-cycle strobes
    logic  vec;
    logic  rsp_vld_p0;
    logic  osd_ok;
    logic  credit_ok;
    sum_t  credit_sum;
    logic  req_vld;
    logic  req;
    logic  buf_wr;
    logic  buf_rd;
    addr_t req_addr;
    addr_t rsp_addr_p0;

    // ---- request / response decode (stage p0: current bus cycle) ----

    // Request is gated by the vector strobe, the outstanding limit and the
    // buffer credit; a response is buffered only if it is not stale.
    always_comb begin
        vec         = bus.exs_pc_wr_i;
        rsp_vld_p0  = bus.irspvalid_i;
        osd_ok      = (osd_q < OSD_LIM);
        credit_sum  = sum_t'(fifo_cnt_q) + sum_t'(live_q);
        credit_ok   = (credit_sum < FIFO_LIM);
        req_vld     = ~vec & osd_ok & credit_ok;
        req         = req_vld & bus.ireqready_i;
        buf_wr      = rsp_vld_p0 & ~vec & (drop_q == '0);
        buf_rd      = bus.ids_ack_i & ~vec & (fifo_cnt_q != '0);
        req_addr    = {pc_q[`RV_XLEN-1:2], 2'b00};
        rsp_addr_p0 = aq_mem[aq_rd_q];
    end

    assign bus.ireqvalid_o = req_vld;
    assign bus.ireqaddr_o  = req_addr;
    assign bus.ireqhpl_o   = bus.exs_hpl_i;
    assign bus.irspready_o = 1'b1;

    // ---- buffered entry (stage p1: one cycle after the response) ----

    assign bus.ids_dav_o   = (fifo_cnt_q != '0);
    assign bus.ids_sofid_o = fb_sofid[fb_rd_q];
    assign bus.ids_ins_o   = fb_ins[fb_rd_q];
    assign bus.ids_ferr_o  = fb_ferr[fb_rd_q];
    assign bus.ids_pc_o    = fb_pc[fb_rd_q];

    // Fetch pointer, outstanding count and address-queue pointers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q    <= C_RESET_VECTOR;
            osd_q   <= '0;
            aq_wr_q <= '0;
            aq_rd_q <= '0;
        end else begin
            if (vec) begin
                pc_q <= bus.exs_pc_din_i;
            end else if (req) begin
                pc_q <= pc_q + `RV_XLEN'(4);
            end
            osd_q <= ocnt_step(osd_q, req, rsp_vld_p0);
            if (req) begin
                aq_wr_q <= aq_wr_q + 1'b1;
            end
            if (rsp_vld_p0) begin
                aq_rd_q <= aq_rd_q + 1'b1;
            end
        end
    end

    // Stale-response bookkeeping and start-of-flow tagging across vectors.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            live_q      <= '0;
            drop_q      <= '0;
            jump_pend_q <= 1'b1;
        end else if (vec) begin
            // a response arriving with the vector is discarded right here,
            // so it is not left behind in the drop count
            drop_q      <= osd_q - ocnt_t'(rsp_vld_p0);
            live_q      <= '0;
            jump_pend_q <= 1'b1;
        end else begin
            if (rsp_vld_p0 && (drop_q != '0)) begin
                drop_q <= drop_q - 1'b1;
            end
            live_q <= ocnt_step(live_q, req, buf_wr);
            if (buf_wr) begin
                jump_pend_q <= 1'b0;
            end
        end
    end

    // Instruction buffer occupancy and pointers; a vector empties it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fifo_cnt_q <= '0;
            fb_wr_q    <= '0;
            fb_rd_q    <= '0;
        end else if (vec) begin
            fifo_cnt_q <= '0;
            fb_rd_q    <= fb_wr_q;
        end else begin
            fifo_cnt_q <= fcnt_step(fifo_cnt_q, buf_wr, buf_rd);
            if (buf_wr) begin
                fb_wr_q <= fb_wr_q + 1'b1;
            end
            if (buf_rd) begin
                fb_rd_q <= fb_rd_q + 1'b1;
            end
        end
    end

    // Remember the address of each issued request for its response.
    always_ff @(posedge clk_i) begin
        if (req) begin
            aq_mem[aq_wr_q] <= req_addr;
        end
    end

    // Capture a non-stale response into the instruction buffer.
    always_ff @(posedge clk_i) begin
        if (buf_wr) begin
            fb_ins[fb_wr_q]   <= bus.irspdata_i[31:0];
            fb_pc[fb_wr_q]    <= rsp_addr_p0;
            fb_ferr[fb_wr_q]  <= bus.irsprerr_i;
            fb_sofid[fb_wr_q] <= jump_pend_q ? `RV_SOFID_JUMP : `RV_SOFID_RUN;
        end
    end

endmodule

// File: tb/tb_merlin_pfu_mo.sv
// Bench for merlin_pfu_mo: scenario tasks drive the ibus/decoder/execute
// inputs cycle by cycle; expected buffer entries are queued when a response
// is driven and compared when the decoder side presents and consumes them.
`ifndef RV_XLEN
`define RV_XLEN 32
`endif
`ifndef RV_SOFID_SZ
`define RV_SOFID_SZ 2
`endif
`ifndef RV_SOFID_RUN
`define RV_SOFID_RUN 2'b00
`endif
`ifndef RV_SOFID_JUMP
`define RV_SOFID_JUMP 2'b01
`endif

module tb_merlin_pfu_mo;

    localparam logic [1:0] JMP = `RV_SOFID_JUMP;
    localparam logic [1:0] RUN = `RV_SOFID_RUN;

    typedef logic [66:0] ent_t; // {sofid, ferr, pc, ins}

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    merlin_pfu_mo_if bus ();

    merlin_pfu_mo dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.master)
    );

    ent_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        obs_vld;
    logic        obs_dav;
    logic [31:0] obs_addr;
    ent_t        obs_head;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    function automatic ent_t mk(input logic [1:0] s, input logic e, input logic [31:0] a);
        return {s, e, a, rom(a)};
    endfunction

    // One clock: drive inputs at the falling edge, sample 1 ns later, and
    // return at the next falling edge.
    task automatic cyc(input logic rdy, input logic rv, input logic rerr,
                       input logic [31:0] rdata, input logic pcwr,
                       input logic [31:0] din, input logic ack);
        bus.ireqready_i  = rdy;
        bus.irspvalid_i  = rv;
        bus.irsprerr_i   = rerr;
        bus.irspdata_i   = rdata;
        bus.exs_pc_wr_i  = pcwr;
        bus.exs_pc_din_i = din;
        bus.ids_ack_i    = ack;
        #1;
        obs_vld  = bus.ireqvalid_o;
        obs_addr = bus.ireqaddr_o;
        obs_dav  = bus.ids_dav_o;
        obs_head = {bus.ids_sofid_o, bus.ids_ferr_o, bus.ids_pc_o, bus.ids_ins_o};
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.ireqready_i  = 1'b0;
        bus.irspvalid_i  = 1'b0;
        bus.irsprerr_i   = 1'b0;
        bus.irspdata_i   = '0;
        bus.exs_pc_wr_i  = 1'b0;
        bus.exs_pc_din_i = '0;
        bus.exs_hpl_i    = 2'b00;
        bus.ids_ack_i    = 1'b0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ent_t e;
        rst              = 1'b1;
        bus.ireqready_i  = 1'b0;
        bus.irspvalid_i  = 1'b0;
        bus.irsprerr_i   = 1'b0;
        bus.irspdata_i   = '0;
        bus.exs_pc_wr_i  = 1'b0;
        bus.exs_pc_din_i = '0;
        bus.exs_hpl_i    = 2'b00;
        bus.ids_ack_i    = 1'b0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.ids_dav_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_dav: got %b want 0", bus.ids_dav_o);
        end
        n_tests++;
        if (bus.ireqaddr_o !== 32'h0) begin
            n_fail++; $display("FAIL rst_addr: got %h want 00000000", bus.ireqaddr_o);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if ({bus.ireqvalid_o, bus.irspready_o} !== 2'b11) begin
            n_fail++; $display("FAIL rst_vld_rdy: got %b%b want 11", bus.ireqvalid_o, bus.irspready_o);
        end
        bus.exs_hpl_i = 2'b10;
        #1;
        n_tests++;
        if (bus.ireqhpl_o !== 2'b10) begin
            n_fail++; $display("FAIL hpl: got %b want 10", bus.ireqhpl_o);
        end
        bus.exs_pc_wr_i  = 1'b1;
        bus.exs_pc_din_i = 32'h40;
        #1;
        n_tests++;
        if (bus.ireqvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL vec_blocks_req: got %b want 0", bus.ireqvalid_o);
        end
        bus.exs_pc_wr_i = 1'b0;
        bus.exs_hpl_i   = 2'b00;
        @(negedge clk);
        // acks on an empty buffer must be ignored
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_tests++;
        if ({obs_vld, obs_addr} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL rst_first_req: got vld=%b addr=%h want vld=1 addr=00000000", obs_vld, obs_addr);
        end
        sb.push_back(mk(JMP, 1'b0, 32'h0));
        cyc(1'b0, 1'b1, 1'b0, rom(32'h0), 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        n_tests++;
        e = sb.pop_front();
        if ({obs_dav, obs_head} !== {1'b1, e}) begin
            n_fail++; $display("FAIL empty_ack_entry: got dav=%b %h want dav=1 %h", obs_dav, obs_head, e);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_tests++;
        if (obs_dav !== 1'b0) begin
            n_fail++; $display("FAIL empty_after_ack: got %b want 0", obs_dav);
        end
    endtask

    task automatic test_back_to_back();
        ent_t        e;
        logic [31:0] ra;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ra = (k > 0) ? 32'(4 * (k - 1)) : 32'h0;
            if (k > 0) sb.push_back(mk((k == 1) ? JMP : RUN, 1'b0, ra));
            cyc(k < 3, k > 0, 1'b0, rom(ra), 1'b0, 32'h0, 1'b0);
            n_tests++;
            if (obs_dav !== (k >= 2)) begin
                n_fail++; $display("FAIL b2b_dav k=%0d: got %b want %b", k, obs_dav, (k >= 2));
            end
            if (k < 3) begin
                n_tests++;
                if ({obs_vld, obs_addr} !== {1'b1, 32'(4 * k)}) begin
                    n_fail++; $display("FAIL b2b_addr k=%0d: got vld=%b addr=%h want vld=1 addr=%h", k, obs_vld, obs_addr, 32'(4 * k));
                end
            end
            if (k == 2) begin
                n_tests++;
                if (obs_head !== sb[0]) begin
                    n_fail++; $display("FAIL b2b_latency_head: got %h want %h", obs_head, sb[0]);
                end
            end
        end
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            if (obs_dav) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra: got %h want no entry", obs_head);
                end else begin
                    e = sb.pop_front();
                    if (obs_head !== e) begin
                        n_fail++; $display("FAIL b2b_entry: got %h want %h", obs_head, e);
                    end
                end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL b2b_missing: got %0d left want 0", sb.size());
        end
    endtask

    task automatic test_osd_limit();
        int          nreq;
        logic [31:0] ea;
        do_reset();
        nreq = 0;
        ea   = 32'h0;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            if (obs_vld) begin
                n_tests++;
                if (obs_addr !== ea) begin
                    n_fail++; $display("FAIL osd_addr: got %h want %h", obs_addr, ea);
                end
                ea = ea + 32'd4;
                nreq++;
            end
        end
        n_tests++;
        if (nreq != 4) begin
            n_fail++; $display("FAIL osd_count: got %0d want 4", nreq);
        end
        n_tests++;
        if (obs_vld !== 1'b0) begin
            n_fail++; $display("FAIL osd_full_vld: got %b want 0", obs_vld);
        end
    endtask

    task automatic test_vector();
        ent_t e;
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        n_tests++;
        if (obs_vld !== 1'b0) begin
            n_fail++; $display("FAIL vec_vld: got %b want 0", obs_vld);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, 1'b0, rom(32'(4 * k)), 1'b0, 32'h0, 1'b0);
            n_tests++;
            if (obs_dav !== 1'b0) begin
                n_fail++; $display("FAIL vec_drop_dav k=%0d: got %b want 0", k, obs_dav);
            end
        end
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_tests++;
        if ({obs_dav, obs_vld, obs_addr} !== {1'b0, 1'b1, 32'h100}) begin
            n_fail++; $display("FAIL vec_target: got dav=%b vld=%b addr=%h want dav=0 vld=1 addr=00000100", obs_dav, obs_vld, obs_addr);
        end
        sb.push_back(mk(JMP, 1'b0, 32'h100));
        cyc(1'b0, 1'b1, 1'b0, rom(32'h100), 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            if (obs_dav) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL vec_extra: got %h want no entry", obs_head);
                end else begin
                    e = sb.pop_front();
                    if (obs_head !== e) begin
                        n_fail++; $display("FAIL vec_entry: got %h want %h", obs_head, e);
                    end
                end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL vec_missing: got %0d left want 0", sb.size());
        end
    endtask

    task automatic test_buffer_full();
        ent_t        e;
        int          nreq;
        logic [31:0] ra;
        logic        rv;
        do_reset();
        nreq = 0;
        for (int k = 0; k < 6; k++) begin
            ra = (k > 0) ? 32'(4 * (k - 1)) : 32'h0;
            rv = (k > 0) && (k <= 4);
            if (rv) sb.push_back(mk((k == 1) ? JMP : RUN, 1'b0, ra));
            cyc(1'b1, rv, 1'b0, rom(ra), 1'b0, 32'h0, 1'b0);
            if (obs_vld) nreq++;
        end
        n_tests++;
        if ({nreq, obs_vld} !== {32'd4, 1'b0}) begin
            n_fail++; $display("FAIL full_stall: got reqs=%0d vld=%b want reqs=4 vld=0", nreq, obs_vld);
        end
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        n_tests++;
        e = sb.pop_front();
        if ({obs_vld, obs_dav, obs_head} !== {1'b0, 1'b1, e}) begin
            n_fail++; $display("FAIL full_ack: got vld=%b dav=%b %h want vld=0 dav=1 %h", obs_vld, obs_dav, obs_head, e);
        end
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_tests++;
        if ({obs_vld, obs_addr} !== {1'b1, 32'h10}) begin
            n_fail++; $display("FAIL full_refill: got vld=%b addr=%h want vld=1 addr=00000010", obs_vld, obs_addr);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_tests++;
        if (obs_vld !== 1'b0) begin
            n_fail++; $display("FAIL full_one_only: got %b want 0", obs_vld);
        end
        sb.push_back(mk(RUN, 1'b0, 32'h10));
        cyc(1'b0, 1'b1, 1'b0, rom(32'h10), 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            if (obs_dav) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL full_extra: got %h want no entry", obs_head);
                end else begin
                    e = sb.pop_front();
                    if (obs_head !== e) begin
                        n_fail++; $display("FAIL full_entry: got %h want %h", obs_head, e);
                    end
                end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL full_missing: got %0d left want 0", sb.size());
        end
    endtask

    task automatic test_ferr();
        ent_t        e;
        logic [31:0] ra;
        logic        rv;
        logic        er;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            ra = (k > 0) ? 32'(4 * (k - 1)) : 32'h0;
            rv = (k > 0);
            er = rv && (ra == 32'h8);
            if (rv) sb.push_back(mk((k == 1) ? JMP : RUN, er, ra));
            cyc(k < 4, rv, er, rom(ra), 1'b0, 32'h0, 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            if (obs_dav) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL ferr_extra: got %h want no entry", obs_head);
                end else begin
                    e = sb.pop_front();
                    if (obs_head !== e) begin
                        n_fail++; $display("FAIL ferr_entry: got %h want %h", obs_head, e);
                    end
                end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL ferr_missing: got %0d left want 0", sb.size());
        end
    endtask

    task automatic test_simul_rw();
        ent_t        e;
        logic [31:0] ra;
        logic        rv;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            ra = (k > 0) ? 32'(4 * (k - 1)) : 32'h0;
            rv = (k >= 1) && (k <= 6);
            if (rv) sb.push_back(mk((k == 1) ? JMP : RUN, 1'b0, ra));
            cyc(k < 6, rv, 1'b0, rom(ra), 1'b0, 32'h0, 1'b1);
            if (k < 6) begin
                n_tests++;
                if ({obs_vld, obs_addr} !== {1'b1, 32'(4 * k)}) begin
                    n_fail++; $display("FAIL stream_req k=%0d: got vld=%b addr=%h want vld=1 addr=%h", k, obs_vld, obs_addr, 32'(4 * k));
                end
            end
            if (obs_dav) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra: got %h want no entry", obs_head);
                end else begin
                    e = sb.pop_front();
                    if (obs_head !== e) begin
                        n_fail++; $display("FAIL stream_entry: got %h want %h", obs_head, e);
                    end
                end
            end
        end
        n_tests++;
        if ({sb.size(), obs_dav} !== {32'd0, 1'b0}) begin
            n_fail++; $display("FAIL stream_missing: got left=%0d dav=%b want left=0 dav=0", sb.size(), obs_dav);
        end
    endtask

    task automatic test_rsp_vector();
        ent_t e;
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, rom(32'h0), 1'b1, 32'h200, 1'b0);
        n_tests++;
        if (obs_vld !== 1'b0) begin
            n_fail++; $display("FAIL rv_vec_vld: got %b want 0", obs_vld);
        end
        cyc(1'b0, 1'b1, 1'b0, rom(32'h4), 1'b0, 32'h0, 1'b0);
        n_tests++;
        if (obs_dav !== 1'b0) begin
            n_fail++; $display("FAIL rv_same_cycle_dav: got %b want 0", obs_dav);
        end
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_tests++;
        if ({obs_dav, obs_vld, obs_addr} !== {1'b0, 1'b1, 32'h200}) begin
            n_fail++; $display("FAIL rv_drop_one: got dav=%b vld=%b addr=%h want dav=0 vld=1 addr=00000200", obs_dav, obs_vld, obs_addr);
        end
        sb.push_back(mk(JMP, 1'b0, 32'h200));
        cyc(1'b0, 1'b1, 1'b0, rom(32'h200), 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            if (obs_dav) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL rv_extra: got %h want no entry", obs_head);
                end else begin
                    e = sb.pop_front();
                    if (obs_head !== e) begin
                        n_fail++; $display("FAIL rv_entry: got %h want %h", obs_head, e);
                    end
                end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL rv_missing: got %0d left want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_osd_limit();
        test_vector();
        test_buffer_full();
        test_ferr();
        test_simul_rw();
        test_rsp_vector();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
